pred_checker: RTL and testbench

Branch-prediction resolution checker placed directly downstream of the gshare predictor. Queues each issued prediction (direction plus target PC) in order until the execute stage resolves the branch. Compares prediction against outcome and produces a registered redirect on mispredict, flushing all younger queued predictions. Maintains saturating accuracy counters for the performance bench.

---
 rtl/pred_checker.sv | 128 ++++++++++++
 tb/tb_pred_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_checker.sv
// Branch-prediction resolution checker: queues issued predictions in order, compares them
// against execute-stage outcomes, flags mispredicts with a registered redirect, keeps stats.
module pred_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     pred_valid_i,
    input  logic                     pred_taken_i,
    input  logic [31:0]              pred_pc_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [31:0]              res_pc_i,
    input  logic                     clear_i,
    output logic                     mispredict_o,
    output logic [31:0]              redirect_pc_o,
    output logic [$clog2(DEPTH):0]   occ_o,
    output logic [CNT_W-1:0]         total_o,
    output logic [CNT_W-1:0]         correct_o,
    output logic                     orphan_o,
    output logic                     drop_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]      OccFull = DEPTH[PW:0];
    localparam logic [PW:0]      OccOne  = 1;
    localparam logic [PW-1:0]    PtrOne  = 1;
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = 1;

    logic              taken_q [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]       occ_q, occ_d;
    logic [CNT_W-1:0]  total_q, total_d, correct_q, correct_d;
    logic              orphan_q, orphan_d, drop_q, drop_d;
    logic              mis_q;
    logic [31:0]       redirect_q, redirect_d;

    logic empty, full, pop, push, hit, mis;

    assign empty        = (occ_q == '0);
    assign full         = (occ_q == OccFull);
    assign pop          = res_valid_i & ~empty;
    assign pred_ready_o = ~full | pop;
    assign push         = pred_valid_i & pred_ready_o;
    // Not-taken predictions match on direction alone; the stored PC is meaningless then.
    assign hit = (taken_q[rptr_q] == res_taken_i) && (!res_taken_i || pc_q[rptr_q] == res_pc_i);
    assign mis = pop & ~hit;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (mis) begin
            // Flush: the same-cycle push is younger than the mispredicted branch.
            rptr_d = rptr_q + PtrOne;
            wptr_d = rptr_q + PtrOne;
            occ_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + PtrOne;
            if (pop)  rptr_d = rptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + OccOne;
                2'b01:   occ_d = occ_q - OccOne;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_comb begin
        total_d    = total_q;
        correct_d  = correct_q;
        orphan_d   = orphan_q | (res_valid_i & empty);
        drop_d     = drop_q | (pred_valid_i & ~pred_ready_o);
        redirect_d = mis ? res_pc_i : redirect_q;
        if (pop && total_q != CntMax)          total_d   = total_q + CntOne;
        if (pop && hit && correct_q != CntMax) correct_d = correct_q + CntOne;
        if (clear_i) begin
            total_d   = '0;
            correct_d = '0;
            orphan_d  = 1'b0;
            drop_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            total_q    <= '0;
            correct_q  <= '0;
            orphan_q   <= 1'b0;
            drop_q     <= 1'b0;
            mis_q      <= 1'b0;
            redirect_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            occ_q      <= occ_d;
            total_q    <= total_d;
            correct_q  <= correct_d;
            orphan_q   <= orphan_d;
            drop_q     <= drop_d;
            mis_q      <= mis;
            redirect_q <= redirect_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !mis) begin
            taken_q[wptr_q] <= pred_taken_i;
            pc_q[wptr_q]    <= pred_pc_i;
        end
    end

    assign mispredict_o  = mis_q;
    assign redirect_pc_o = redirect_q;
    assign occ_o         = occ_q;
    assign total_o       = total_q;
    assign correct_o     = correct_q;
    assign orphan_o      = orphan_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_pred_checker.sv
// Scoreboard bench for pred_checker: stimulus queues expected redirect behaviour per resolve,
// a monitor pops and compares one cycle later. A CNT_W=4 twin checks counter saturation.
module tb_pred_checker;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        pred_valid_i, pred_taken_i, res_valid_i, res_taken_i, clear_i;
    logic [31:0] pred_pc_i, res_pc_i;

    logic        ready, mis, orphan, drop;
    logic [31:0] rpc;
    logic [2:0]  occ;
    logic [15:0] total, correct;

    logic        ready4, mis4, orphan4, drop4;
    logic [31:0] rpc4;
    logic [2:0]  occ4;
    logic [3:0]  total4, correct4;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        mis;
        logic [31:0] pc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    pred_checker #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i), .pred_pc_i(pred_pc_i),
        .pred_ready_o(ready),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_pc_i(res_pc_i),
        .clear_i(clear_i), .mispredict_o(mis), .redirect_pc_o(rpc), .occ_o(occ),
        .total_o(total), .correct_o(correct), .orphan_o(orphan), .drop_o(drop)
    );

    pred_checker #(.DEPTH(4), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i), .pred_pc_i(pred_pc_i),
        .pred_ready_o(ready4),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_pc_i(res_pc_i),
        .clear_i(clear_i), .mispredict_o(mis4), .redirect_pc_o(rpc4), .occ_o(occ4),
        .total_o(total4), .correct_o(correct4), .orphan_o(orphan4), .drop_o(drop4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic t, input logic [31:0] pc);
        pred_valid_i = 1'b1;
        pred_taken_i = t;
        pred_pc_i    = pc;
        tick();
        pred_valid_i = 1'b0;
    endtask

    // One resolve, optionally with a same-cycle push; exp_mis/exp_pc are hand-derived.
    task automatic resolve(input logic rt, input logic [31:0] rpc_in, input logic exp_mis,
                           input logic pv, input logic pt, input logic [31:0] ppc);
        res_valid_i  = 1'b1;
        res_taken_i  = rt;
        res_pc_i     = rpc_in;
        pred_valid_i = pv;
        pred_taken_i = pt;
        pred_pc_i    = ppc;
        exp_q.push_back('{mis: exp_mis, pc: rpc_in});
        tick();
        res_valid_i  = 1'b0;
        pred_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // Entry k of the streaming tests: taken unless k is a multiple of 3.
    function automatic logic ent_t(input int k);
        return (k % 3) != 0;
    endfunction
    function automatic logic [31:0] ent_pc(input int k);
        return 32'h1000 + 32'(4 * k);
    endfunction
    function automatic logic [31:0] res_pc_for(input int k);
        return ent_t(k) ? ent_pc(k) : 32'h2000 + 32'(k);
    endfunction

    // Monitor: one cycle after each resolve edge the redirect outputs must match the scoreboard.
    always @(posedge clk_i) begin
        logic fired;
        exp_t e;
        fired = res_valid_i && reset_ni;
        #3;
        if (fired) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: resolve seen with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("mispredict", 32'(mis), 32'(e.mis));
                chk("mispredict_cnt4", 32'(mis4), 32'(e.mis));
                if (e.mis) chk("redirect_pc", rpc, e.pc);
            end
        end else begin
            chk("no_spurious_mispredict", 32'(mis), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_ni = 1'b0;
        {pred_valid_i, pred_taken_i, res_valid_i, res_taken_i, clear_i} = '0;
        pred_pc_i = '0;
        res_pc_i  = '0;
        #2;
        chk("rst_occ", 32'(occ), 0);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_mis", 32'(mis), 0);
        chk("rst_redirect", rpc, 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_correct", 32'(correct), 0);
        chk("rst_orphan", 32'(orphan), 0);
        chk("rst_drop", 32'(drop), 0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // Fill, then overflow.
        push(1'b1, 32'h100);
        push(1'b0, 32'h0);
        push(1'b1, 32'h200);
        push(1'b0, 32'h0);
        chk("fill_occ", 32'(occ), 4);
        chk("fill_ready", 32'(ready), 0);
        push(1'b1, 32'h300);
        chk("over_drop", 32'(drop), 1);
        chk("over_occ", 32'(occ), 4);

        // Drain with correct resolves.
        resolve(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h44,  1'b0, 1'b0, 1'b0, 32'h0);
        resolve(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        resolve(1'b0, 32'h48,  1'b0, 1'b0, 1'b0, 32'h0);
        chk("drain_total", 32'(total), 4);
        chk("drain_correct", 32'(correct), 4);
        chk("drain_occ", 32'(occ), 0);

        // Target mispredict with a same-cycle push, which must be discarded silently.
        do_clear();
        chk("clr_drop", 32'(drop), 0);
        push(1'b1, 32'h100);
        push(1'b1, 32'h110);
        push(1'b0, 32'h0);
        resolve(1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 32'h500);
        chk("mis_occ", 32'(occ), 0);
        chk("mis_total", 32'(total), 1);
        chk("mis_correct", 32'(correct), 0);
        chk("mis_drop", 32'(drop), 0);

        // Full queue streaming: push and correct resolve together, pointers wrap.
        for (int k = 0; k < 4; k++) push(ent_t(k), ent_pc(k));
        res_valid_i = 1'b1;
        #1;
        chk("full_pop_ready", 32'(ready), 1);
        res_valid_i = 1'b0;
        for (int i = 0; i < 20; i++)
            resolve(ent_t(i), res_pc_for(i), 1'b0, 1'b1, ent_t(i + 4), ent_pc(i + 4));
        chk("stream_occ", 32'(occ), 4);
        chk("stream_total", 32'(total), 21);
        chk("stream_correct", 32'(correct), 20);
        chk("stream_drop", 32'(drop), 0);
        chk("redirect_hold", rpc, 32'h104);

        // Drain, orphan resolve with accepted push, then clear keeps the queue.
        for (int k = 20; k < 24; k++) resolve(ent_t(k), res_pc_for(k), 1'b0, 1'b0, 1'b0, 0);
        chk("drain2_total", 32'(total), 25);
        chk("drain2_occ", 32'(occ), 0);
        resolve(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 32'h3000);
        chk("orphan_flag", 32'(orphan), 1);
        chk("orphan_total", 32'(total), 25);
        chk("orphan_push_occ", 32'(occ), 1);
        do_clear();
        chk("clr_orphan", 32'(orphan), 0);
        chk("clr_total", 32'(total), 0);
        chk("clr_correct", 32'(correct), 0);
        chk("clr_occ", 32'(occ), 1);
        resolve(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("intact_total", 32'(total), 1);
        chk("intact_correct", 32'(correct), 1);
        chk("intact_occ", 32'(occ), 0);

        // Saturation on the 4-bit twin.
        do_clear();
        push(ent_t(100), ent_pc(100));
        for (int i = 0; i < 19; i++)
            resolve(ent_t(100 + i), res_pc_for(100 + i), 1'b0, 1'b1, ent_t(101 + i),
                    ent_pc(101 + i));
        resolve(ent_t(119), res_pc_for(119), 1'b0, 1'b0, 1'b0, 0);
        chk("sat_total4", 32'(total4), 15);
        chk("sat_correct4", 32'(correct4), 15);
        chk("wide_total", 32'(total), 20);
        chk("wide_correct", 32'(correct), 20);

        // Asynchronous reset mid-stream.
        push(1'b1, 32'h4000);
        push(1'b0, 32'h0);
        chk("pre_rst_occ", 32'(occ), 2);
        reset_ni = 1'b0;
        #1;
        chk("arst_occ", 32'(occ), 0);
        chk("arst_ready", 32'(ready), 1);
        chk("arst_redirect", rpc, 0);
        chk("arst_total", 32'(total), 0);
        chk("arst_correct", 32'(correct), 0);
        chk("arst_total4", 32'(total4), 0);
        chk("arst_correct4", 32'(correct4), 0);
        chk("arst_flags", 32'({orphan, drop, mis, orphan4, drop4, mis4}), 0);
        chk("arst_occ4", 32'(occ4), 0);
        tick();
        reset_ni = 1'b1;
        tick();
        chk("post_rst_occ", 32'(occ), 0);
        chk("post_rst_ready4", 32'(ready4), 1);
        chk("post_rst_redirect4", rpc4, 0);

        tick();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
